// File: rtl/ita_requant_pkg.sv
// Shared widths, int8 limits and the requant configuration bundle used by
// the GELU and softmax requantization back-ends.
package ita_requant_pkg;

  localparam int unsigned IN_W    = 26;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned MULT_W  = 8;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned CNT_W   = 16;

  localparam int unsigned PROD_W  = IN_W + MULT_W + 1;
  // One guard bit above the product so rounding and offset cannot overflow.
  localparam int unsigned ACC_W   = PROD_W + 1;

  localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
  localparam int OUT_MIN = -(1 << (OUT_W - 1));

  typedef struct packed {
    logic [MULT_W-1:0]  mult;
    logic [SHIFT_W-1:0] shift;
    logic [OUT_W-1:0]   add;
  } requant_cfg_t;

endpackage

// File: rtl/ita_requant_round_clamp.sv
// Combinational round-half-up shift, signed offset and int8 clamp.
// Shared by the GELU and softmax requant paths.
module ita_requant_round_clamp
  import ita_requant_pkg::*;
(
  input  logic signed [PROD_W-1:0]  prod,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic signed [OUT_W-1:0]   add,
  output logic signed [OUT_W-1:0]   data,
  output logic                      sat
);

  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] biased;

  always_comb begin
    rnd = '0;
    if (shift != '0) begin
      rnd = ACC_W'(1) << (shift - SHIFT_W'(1));
    end
    sum     = ACC_W'(prod) + rnd;
    shifted = sum >>> shift;
    biased  = shifted + ACC_W'(add);

    data = biased[OUT_W-1:0];
    sat  = 1'b0;
    if (biased > ACC_W'(OUT_MAX)) begin
      data = OUT_W'(OUT_MAX);
      sat  = 1'b1;
    end else if (biased < ACC_W'(OUT_MIN)) begin
      data = OUT_W'(OUT_MIN);
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/ita_gelu_requant.sv
// GELU back-end requantizer: 2-stage elastic pipeline turning the 26-bit
// accumulator stream into int8 activations, with a saturation event counter.
module ita_gelu_requant
  import ita_requant_pkg::*;
(
  input  logic                      io_clk,
  input  logic                      io_rst_ni,
  input  logic                      io_in_valid_i,
  output logic                      io_in_ready_o,
  input  logic signed [IN_W-1:0]    io_data_i,
  input  logic        [MULT_W-1:0]  io_mult_i,
  input  logic        [SHIFT_W-1:0] io_shift_i,
  input  logic signed [OUT_W-1:0]   io_add_i,
  output logic                      io_out_valid_o,
  input  logic                      io_out_ready_i,
  output logic signed [OUT_W-1:0]   io_data_o,
  output logic                      io_sat_o,
  input  logic                      io_sat_clr_i,
  output logic        [CNT_W-1:0]   io_sat_cnt_o
);

  requant_cfg_t             cfgIn;
  logic signed [MULT_W:0]   multS;
  logic signed [PROD_W-1:0] prodC;

  logic                     s1Valid;
  logic signed [PROD_W-1:0] s1Prod;
  logic        [SHIFT_W-1:0] s1Shift;
  logic signed [OUT_W-1:0]  s1Add;

  logic                     s1Load;
  logic                     s2Load;
  logic                     outFire;
  logic signed [OUT_W-1:0]  rcData;
  logic                     rcSat;

  assign cfgIn = '{mult: io_mult_i, shift: io_shift_i, add: io_add_i};

  // Multiplier is unsigned: zero-extend before the signed multiply.
  assign multS = {1'b0, cfgIn.mult};
  assign prodC = PROD_W'(io_data_i) * PROD_W'(multS);

  // Ready chains combinationally back from the consumer.
  assign s2Load        = !io_out_valid_o || io_out_ready_i;
  assign s1Load        = !s1Valid || s2Load;
  assign io_in_ready_o = s1Load;
  assign outFire       = io_out_valid_o && io_out_ready_i;

  always_ff @(posedge io_clk or negedge io_rst_ni) begin
    if (!io_rst_ni) begin
      s1Valid <= 1'b0;
      s1Prod  <= '0;
      s1Shift <= '0;
      s1Add   <= '0;
    end else if (s1Load) begin
      s1Valid <= io_in_valid_i;
      if (io_in_valid_i) begin
        s1Prod  <= prodC;
        s1Shift <= cfgIn.shift;
        s1Add   <= cfgIn.add;
      end
    end
  end

  ita_requant_round_clamp u_roundClamp (
    .prod  (s1Prod),
    .shift (s1Shift),
    .add   (s1Add),
    .data  (rcData),
    .sat   (rcSat)
  );

  always_ff @(posedge io_clk or negedge io_rst_ni) begin
    if (!io_rst_ni) begin
      io_out_valid_o <= 1'b0;
      io_data_o      <= '0;
      io_sat_o       <= 1'b0;
    end else if (s2Load) begin
      io_out_valid_o <= s1Valid;
      if (s1Valid) begin
        io_data_o <= rcData;
        io_sat_o  <= rcSat;
      end
    end
  end

  // Clear wins over a same-cycle increment; counter sticks at all-ones.
  always_ff @(posedge io_clk or negedge io_rst_ni) begin
    if (!io_rst_ni) begin
      io_sat_cnt_o <= '0;
    end else if (io_sat_clr_i) begin
      io_sat_cnt_o <= '0;
    end else if (outFire && io_sat_o && (io_sat_cnt_o != '1)) begin
      io_sat_cnt_o <= io_sat_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ita_gelu_requant.sv
// Self-checking bench for ita_gelu_requant: directed vector table, elastic
// flow sequences and a randomized stream against an arithmetic model.
module tb_ita_gelu_requant;
  import ita_requant_pkg::*;

  logic                      io_clk = 1'b0;
  logic                      io_rst_ni;
  logic                      io_in_valid_i;
  logic                      io_in_ready_o;
  logic signed [IN_W-1:0]    io_data_i;
  logic        [MULT_W-1:0]  io_mult_i;
  logic        [SHIFT_W-1:0] io_shift_i;
  logic signed [OUT_W-1:0]   io_add_i;
  logic                      io_out_valid_o;
  logic                      io_out_ready_i;
  logic signed [OUT_W-1:0]   io_data_o;
  logic                      io_sat_o;
  logic                      io_sat_clr_i;
  logic        [CNT_W-1:0]   io_sat_cnt_o;

  ita_gelu_requant dut (
    .io_clk         (io_clk),
    .io_rst_ni      (io_rst_ni),
    .io_in_valid_i  (io_in_valid_i),
    .io_in_ready_o  (io_in_ready_o),
    .io_data_i      (io_data_i),
    .io_mult_i      (io_mult_i),
    .io_shift_i     (io_shift_i),
    .io_add_i       (io_add_i),
    .io_out_valid_o (io_out_valid_o),
    .io_out_ready_i (io_out_ready_i),
    .io_data_o      (io_data_o),
    .io_sat_o       (io_sat_o),
    .io_sat_clr_i   (io_sat_clr_i),
    .io_sat_cnt_o   (io_sat_cnt_o)
  );

  always #5 io_clk = ~io_clk;

  typedef struct {
    int data;
    int mult;
    int shift;
    int add;
    int expData;
    int expSat;
  } vec_t;

  vec_t vecs[15];
  int   tests  = 0;
  int   fails  = 0;
  int   expCnt = 0;
  int   lat;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic of the requant formula.
  function automatic void refModel(input int d, input int m, input int sh, input int ad,
                                   output int q, output int s);
    longint p;
    longint u;
    p = longint'(d) * longint'(m);
    if (sh != 0) p = p + (longint'(1) << (sh - 1));
    u = (p >>> sh) + longint'(ad);
    if (u > 127) begin
      q = 127; s = 1;
    end else if (u < -128) begin
      q = -128; s = 1;
    end else begin
      q = int'(u); s = 0;
    end
  endfunction

  task automatic drive(input int d, input int m, input int sh, input int ad);
    io_data_i  = IN_W'(d);
    io_mult_i  = MULT_W'(m);
    io_shift_i = SHIFT_W'(sh);
    io_add_i   = OUT_W'(ad);
  endtask

  // mode 0: out_ready low in cycles 3..6; mode 1: random valid/ready; mode 2: continuous.
  task automatic runStream(input int mode, input int nBeats);
    int  expQ[$];
    int  expSQ[$];
    int  sent = 0;
    int  got = 0;
    int  gaps = 0;
    bit  have = 0;
    bit  started = 0;
    bit  sawBlock = 0;
    int  curD = 0, curM = 0, curS = 0, curA = 0;
    int  q, s, hd, hs;
    for (int cyc = 0; cyc < 3000 && got < nBeats; cyc++) begin
      if (!have && sent < nBeats) begin
        if (mode == 0) begin
          curD = sent * 20 - 70; curM = 1; curS = 0; curA = 0;
        end else begin
          curD = int'($urandom) >>> (32 - IN_W);
          if ($urandom_range(1) == 1) curD = curD >>> $urandom_range(22);
          curM = int'($urandom_range(255));
          curS = ($urandom_range(1) == 1) ? int'($urandom_range(31)) : int'($urandom_range(8));
          curA = int'($urandom_range(255)) - 128;
        end
        have = 1;
      end
      io_in_valid_i = have && (mode != 1 || $urandom_range(3) != 0);
      drive(curD, curM, curS, curA);
      case (mode)
        0:       io_out_ready_i = !(cyc >= 3 && cyc <= 6);
        1:       io_out_ready_i = ($urandom_range(3) != 0);
        default: io_out_ready_i = 1'b1;
      endcase
      #1;
      if (have && !io_in_ready_o) sawBlock = 1;
      if (io_out_valid_o) started = 1;
      else if (started) gaps++;
      if (io_out_valid_o && !io_out_ready_i && expQ.size() > 0) begin
        check("held_data", longint'(io_data_o), longint'(expQ[0]));
        check("held_sat", longint'(io_sat_o), longint'(expSQ[0]));
      end
      if (io_out_valid_o && io_out_ready_i) begin
        if (expQ.size() == 0) begin
          tests++; fails++;
          $display("FAIL stream_extra_beat: got data %0d, expected no beat", io_data_o);
        end else begin
          hd = expQ.pop_front();
          hs = expSQ.pop_front();
          check("stream_data", longint'(io_data_o), longint'(hd));
          check("stream_sat", longint'(io_sat_o), longint'(hs));
          expCnt += hs;
        end
        got++;
      end
      if (io_in_valid_i && io_in_ready_o) begin
        refModel(curD, curM, curS, curA, q, s);
        expQ.push_back(q);
        expSQ.push_back(s);
        sent++;
        have = 0;
      end
      @(posedge io_clk); #1;
    end
    io_in_valid_i  = 1'b0;
    io_out_ready_i = 1'b1;
    check("stream_beats", longint'(got), longint'(nBeats));
    if (mode == 0) check("stream_ready_dropped", longint'(sawBlock), 1);
    if (mode == 2) check("stream_gaps", longint'(gaps), 0);
    repeat (3) @(posedge io_clk);
    #1;
    check("stream_no_extra", longint'(io_out_valid_o), 0);
    check("stream_sat_cnt", longint'(io_sat_cnt_o), longint'(expCnt));
  endtask

  initial begin
    vecs[0]  = '{200, 5, 4, 2, 65, 0};
    vecs[1]  = '{-200, 5, 4, 2, -60, 0};
    vecs[2]  = '{1, 1, 1, 0, 1, 0};
    vecs[3]  = '{-1, 1, 1, 0, 0, 0};
    vecs[4]  = '{100000, 255, 0, 0, 127, 1};
    vecs[5]  = '{-100000, 255, 0, 0, -128, 1};
    vecs[6]  = '{127, 1, 0, 0, 127, 0};
    vecs[7]  = '{128, 1, 0, 0, 127, 1};
    vecs[8]  = '{-128, 1, 0, 0, -128, 0};
    vecs[9]  = '{-129, 1, 0, 0, -128, 1};
    vecs[10] = '{0, 0, 0, -5, -5, 0};
    vecs[11] = '{-3, 1, 2, 0, -1, 0};
    vecs[12] = '{33554431, 255, 31, 0, 4, 0};
    vecs[13] = '{0, 0, 0, -128, -128, 0};
    vecs[14] = '{1, 1, 0, 127, 127, 1};

    io_rst_ni      = 1'b0;
    io_in_valid_i  = 1'b0;
    io_out_ready_i = 1'b1;
    io_sat_clr_i   = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge io_clk);
    #1;
    check("rst_out_valid", longint'(io_out_valid_o), 0);
    check("rst_in_ready", longint'(io_in_ready_o), 1);
    check("rst_data", longint'(io_data_o), 0);
    check("rst_sat", longint'(io_sat_o), 0);
    check("rst_sat_cnt", longint'(io_sat_cnt_o), 0);
    io_rst_ni = 1'b1;
    @(posedge io_clk); #1;

    // Directed vectors, one beat at a time with latency check.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].data, vecs[i].mult, vecs[i].shift, vecs[i].add);
      io_in_valid_i = 1'b1;
      #1;
      check("vec_in_ready", longint'(io_in_ready_o), 1);
      @(posedge io_clk); #1;
      io_in_valid_i = 1'b0;
      lat = 0;
      for (int k = 2; k <= 8; k++) begin
        @(posedge io_clk); #1;
        if (io_out_valid_o) begin
          lat = k;
          break;
        end
      end
      check("vec_latency", longint'(lat), 2);
      check("vec_data", longint'(io_data_o), longint'(vecs[i].expData));
      check("vec_sat", longint'(io_sat_o), longint'(vecs[i].expSat));
      @(posedge io_clk); #1;
      expCnt += vecs[i].expSat;
      check("vec_sat_cnt", longint'(io_sat_cnt_o), longint'(expCnt));
      check("vec_out_done", longint'(io_out_valid_o), 0);
    end

    // Clear coinciding with a saturating handshake.
    drive(100000, 255, 0, 0);
    io_in_valid_i = 1'b1;
    @(posedge io_clk); #1;
    io_in_valid_i = 1'b0;
    @(posedge io_clk); #1;
    check("clr_out_valid", longint'(io_out_valid_o), 1);
    io_sat_clr_i = 1'b1;
    @(posedge io_clk); #1;
    io_sat_clr_i = 1'b0;
    expCnt = 0;
    check("clr_priority", longint'(io_sat_cnt_o), 0);

    runStream(0, 8);
    runStream(1, 200);
    runStream(2, 30);

    // Continuous saturating stream, then reset mid-stream.
    io_sat_clr_i   = 1'b1;
    io_in_valid_i  = 1'b1;
    io_out_ready_i = 1'b1;
    drive(100000, 255, 0, 0);
    @(posedge io_clk); #1;
    io_sat_clr_i = 1'b0;
    repeat (5) @(posedge io_clk);
    #1;
    check("pre_rst_sat_cnt", longint'(io_sat_cnt_o), 4);
    check("pre_rst_out_valid", longint'(io_out_valid_o), 1);
    io_rst_ni = 1'b0;
    #1;
    check("mid_rst_out_valid", longint'(io_out_valid_o), 0);
    check("mid_rst_sat_cnt", longint'(io_sat_cnt_o), 0);
    io_in_valid_i = 1'b0;
    @(posedge io_clk); #1;
    io_rst_ni = 1'b1;
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge io_clk); #1;
      if (io_out_valid_o) lat++;
    end
    check("post_rst_no_output", longint'(lat), 0);
    check("post_rst_in_ready", longint'(io_in_ready_o), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
